// File: rtl/ps2_pkg.sv
// Shared types, scan codes and key/direction mapping helpers for the PS/2 WASD sequencer.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXTBRK} seq_state_t;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_A    = 3'd1,
    DIR_D    = 3'd2,
    DIR_W    = 3'd3,
    DIR_S    = 3'd4
  } dir_t;

  localparam logic [7:0] SC_W  = 8'h1D;
  localparam logic [7:0] SC_A  = 8'h1C;
  localparam logic [7:0] SC_S  = 8'h1B;
  localparam logic [7:0] SC_D  = 8'h23;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Event key index (W0 A1 S2 D3) differs from held bit order {S,D,A,W}.
  function automatic logic [1:0] key_to_bit(input logic [1:0] key);
    case (key)
      2'd0:    key_to_bit = 2'd0;
      2'd1:    key_to_bit = 2'd1;
      2'd2:    key_to_bit = 2'd3;
      default: key_to_bit = 2'd2;
    endcase
  endfunction

  function automatic dir_t key_to_dir(input logic [1:0] key);
    case (key)
      2'd0:    key_to_dir = DIR_W;
      2'd1:    key_to_dir = DIR_A;
      2'd2:    key_to_dir = DIR_S;
      default: key_to_dir = DIR_D;
    endcase
  endfunction

  function automatic dir_t highest_held(input logic [3:0] held);
    if (held[0])      highest_held = DIR_W;
    else if (held[1]) highest_held = DIR_A;
    else if (held[3]) highest_held = DIR_S;
    else if (held[2]) highest_held = DIR_D;
    else              highest_held = DIR_NONE;
  endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Saturating stall timer: expire pulses when the count reaches TIMEOUT_CYC-1 while enabled.
module ps2_timeout_ctr #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] count_q, count_d;

  assign expire = enable && !clear && (count_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (clear || expire)
      count_d = '0;
    else if (enable && (count_q != TW'(TIMEOUT_CYC)))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Decodes PS/2 byte stream into WASD make/break events, held flags and an arbitrated direction.
// All inputs are sampled on byte_valid; outputs are registered (one-cycle latency).
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       parity_err,
  output logic [2:0] dir,
  output logic [3:0] key_held,
  output logic       event_valid,
  output logic       event_make,
  output logic [1:0] event_key,
  output logic       rx_resync,
  output seq_state_t state_dbg
);

  seq_state_t state_q, state_d;
  dir_t       dir_q, dir_d;
  logic [3:0] held_q, held_d;
  logic       ev_valid_q, ev_valid_d;
  logic       ev_make_q, ev_make_d;
  logic [1:0] ev_key_q, ev_key_d;
  logic       resync_q, resync_d;
  logic       expire;
  logic       is_wasd;
  logic [1:0] key_idx;
  logic [1:0] bit_idx;
  logic       do_make, do_break;

  ps2_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (byte_valid || (state_q == IDLE)),
    .enable  (state_q != IDLE),
    .expire  (expire)
  );

  always_comb begin
    is_wasd = 1'b1;
    key_idx = 2'd0;
    case (byte_data)
      SC_W:    key_idx = 2'd0;
      SC_A:    key_idx = 2'd1;
      SC_S:    key_idx = 2'd2;
      SC_D:    key_idx = 2'd3;
      default: is_wasd = 1'b0;
    endcase
    bit_idx = key_to_bit(key_idx);
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    held_d     = held_q;
    ev_valid_d = 1'b0;
    ev_make_d  = ev_make_q;
    ev_key_d   = ev_key_q;
    resync_d   = 1'b0;
    do_make    = 1'b0;
    do_break   = 1'b0;

    if (byte_valid) begin
      if (parity_err) begin
        state_d  = IDLE;
        resync_d = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (byte_data == SC_E0)      state_d = EXT;
            else if (byte_data == SC_F0) state_d = BRK;
            else                         do_make = is_wasd;
          end
          BRK: begin
            do_break = is_wasd;
            state_d  = IDLE;
          end
          EXT:     state_d = (byte_data == SC_F0) ? EXTBRK : IDLE;
          default: state_d = IDLE;
        endcase
      end
    end else if (expire) begin
      state_d  = IDLE;
      resync_d = 1'b1;
    end

    // Repeats of held keys and releases of idle keys produce no event.
    if (do_make && !held_q[bit_idx]) begin
      held_d[bit_idx] = 1'b1;
      dir_d           = key_to_dir(key_idx);
      ev_valid_d      = 1'b1;
      ev_make_d       = 1'b1;
      ev_key_d        = key_idx;
    end else if (do_break && held_q[bit_idx]) begin
      held_d[bit_idx] = 1'b0;
      if (dir_q == key_to_dir(key_idx))
        dir_d = highest_held(held_d);
      ev_valid_d = 1'b1;
      ev_make_d  = 1'b0;
      ev_key_d   = key_idx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dir_q      <= DIR_NONE;
      held_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_make_q  <= 1'b0;
      ev_key_q   <= '0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      held_q     <= held_d;
      ev_valid_q <= ev_valid_d;
      ev_make_q  <= ev_make_d;
      ev_key_q   <= ev_key_d;
      resync_q   <= resync_d;
    end
  end

  assign dir         = dir_q;
  assign key_held    = held_q;
  assign event_valid = ev_valid_q;
  assign event_make  = ev_make_q;
  assign event_key   = ev_key_q;
  assign rx_resync   = resync_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench: byte driver, event scoreboard with monitor, direct output checks.
module tb_ps2_key_sequencer;
  import ps2_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       parity_err = 1'b0;
  logic [2:0] dir;
  logic [3:0] key_held;
  logic       event_valid;
  logic       event_make;
  logic [1:0] event_key;
  logic       rx_resync;
  seq_state_t state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];

  ps2_key_sequencer #(.TIMEOUT_CYC(100)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .parity_err  (parity_err),
    .dir         (dir),
    .key_held    (key_held),
    .event_valid (event_valid),
    .event_make  (event_make),
    .event_key   (event_key),
    .rx_resync   (rx_resync),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one byte for a single cycle; returns at the negedge where its result is visible.
  task automatic send_byte(input logic [7:0] b, input logic perr = 1'b0);
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    parity_err = perr;
    @(negedge clock);
    byte_valid = 1'b0;
    parity_err = 1'b0;
  endtask

  task automatic expect_ev(input logic make, input logic [1:0] key);
    exp_q.push_back({make, key});
  endtask

  task automatic check_out(input string name, input logic [2:0] d, input logic [3:0] h);
    check({name, " dir"}, 32'(dir), 32'(d));
    check({name, " key_held"}, 32'(key_held), 32'(h));
  endtask

  always @(negedge clock) begin
    if (reset_n && event_valid) begin
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got make=%0d key=%0d expected none", event_make, event_key);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if ({event_make, event_key} !== e) begin
          n_fail++;
          $display("FAIL event: got make=%0d key=%0d expected make=%0d key=%0d",
                   event_make, event_key, e[2], e[1:0]);
        end
      end
    end
  end

  initial begin
    int cnt;
    #12;
    check("reset dir", 32'(dir), 0);
    check("reset key_held", 32'(key_held), 0);
    check("reset event_valid", 32'(event_valid), 0);
    check("reset event_make", 32'(event_make), 0);
    check("reset event_key", 32'(event_key), 0);
    check("reset rx_resync", 32'(rx_resync), 0);
    check("reset state", 32'(state_dbg), 32'(IDLE));
    @(negedge clock);
    reset_n = 1'b1;

    // 1: single make W
    expect_ev(1'b1, 2'd0); send_byte(SC_W); check_out("t1 W", 3, 4'b0001);
    check("t1 event_valid", 32'(event_valid), 1);

    // 2: W, A, release A (dir falls back to W), release W
    expect_ev(1'b1, 2'd1); send_byte(SC_A); check_out("t2 A", 1, 4'b0011);
    send_byte(SC_F0); check_out("t2 F0", 1, 4'b0011);
    expect_ev(1'b0, 2'd1); send_byte(SC_A); check_out("t2 brk A", 3, 4'b0001);
    send_byte(SC_F0);
    expect_ev(1'b0, 2'd0); send_byte(SC_W); check_out("t2 brk W", 0, 4'b0000);

    // 3: typematic repeat suppressed, extended break ignored
    expect_ev(1'b1, 2'd0);
    repeat (5) send_byte(SC_W);
    check_out("t3 rep", 3, 4'b0001);
    send_byte(SC_E0); send_byte(SC_F0); send_byte(SC_W);
    check_out("t3 ext", 3, 4'b0001);

    // break of non-dir key keeps dir; break of dir key picks highest held
    expect_ev(1'b1, 2'd2); send_byte(SC_S); check_out("t3 S", 4, 4'b1001);
    expect_ev(1'b1, 2'd3); send_byte(SC_D); check_out("t3 D", 2, 4'b1101);
    send_byte(SC_F0); expect_ev(1'b0, 2'd0); send_byte(SC_W); check_out("t3 brk W", 2, 4'b1100);
    send_byte(SC_F0); expect_ev(1'b0, 2'd3); send_byte(SC_D); check_out("t3 brk D", 4, 4'b1000);
    send_byte(SC_F0); expect_ev(1'b0, 2'd2); send_byte(SC_S); check_out("t3 brk S", 0, 4'b0000);
    send_byte(SC_F0); send_byte(SC_A); check_out("t3 brk unheld", 0, 4'b0000);
    send_byte(8'h55); check_out("t3 other", 0, 4'b0000);
    send_byte(SC_F0); send_byte(SC_E0);
    check("t3 brk-e0 state", 32'(state_dbg), 32'(IDLE));
    expect_ev(1'b1, 2'd0); send_byte(SC_W); check_out("t3 W after E0", 3, 4'b0001);
    send_byte(SC_F0); expect_ev(1'b0, 2'd0); send_byte(SC_W); check_out("t3 clr", 0, 4'b0000);

    // 4: stalled break prefix times out after 100 cycles
    send_byte(SC_F0);
    check("t4 state BRK", 32'(state_dbg), 32'(BRK));
    cnt = 0;
    while (cnt < 5000 && !rx_resync) begin
      @(negedge clock);
      cnt++;
    end
    check("t4 timeout cycle", 32'(cnt), 100);
    check("t4 state IDLE", 32'(state_dbg), 32'(IDLE));
    @(negedge clock);
    check("t4 resync pulse end", 32'(rx_resync), 0);
    cnt = 0;
    repeat (300) begin
      @(negedge clock);
      if (rx_resync) cnt++;
    end
    check("t4 no resync in IDLE", 32'(cnt), 0);
    expect_ev(1'b1, 2'd2); send_byte(SC_S); check_out("t4 make S", 4, 4'b1000);
    send_byte(SC_F0); expect_ev(1'b0, 2'd2); send_byte(SC_S); check_out("t4 clr", 0, 4'b0000);

    // 5: parity errors discard bytes and resync; held state kept
    expect_ev(1'b1, 2'd0); send_byte(SC_W); check_out("t5 W", 3, 4'b0001);
    send_byte(SC_A, 1'b1);
    check("t5 resync", 32'(rx_resync), 1);
    check_out("t5 perr", 3, 4'b0001);
    @(negedge clock);
    check("t5 resync end", 32'(rx_resync), 0);
    send_byte(SC_F0, 1'b1);
    check("t5 resync f0", 32'(rx_resync), 1);
    check("t5 state", 32'(state_dbg), 32'(IDLE));
    expect_ev(1'b1, 2'd1); send_byte(SC_A); check_out("t5 make A", 1, 4'b0011);

    // 6: asynchronous reset mid-sequence
    expect_ev(1'b1, 2'd3); send_byte(SC_D); check_out("t6 D", 2, 4'b0111);
    send_byte(SC_F0);
    #2 reset_n = 1'b0;
    #1;
    check_out("t6 reset", 0, 4'b0000);
    check("t6 event_key", 32'(event_key), 0);
    check("t6 event_make", 32'(event_make), 0);
    check("t6 state", 32'(state_dbg), 32'(IDLE));
    @(negedge clock);
    reset_n = 1'b1;
    expect_ev(1'b1, 2'd0); send_byte(SC_W); check_out("t6 make W", 3, 4'b0001);

    repeat (3) @(negedge clock);
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
